// File: rtl/fetch_unit.sv
// Instruction-fetch stage for the SimpleRisc core.
// Holds the PC, fetches 32-bit words over a req/ack handshake and presents a decoded
// valid/ready packet to decode. Accepts single-cycle redirects from execute.
// Optional: define FETCH_PERF_CNT_EN to add the perf_fetched / perf_stall counters.
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction memory
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  // Redirect from execute
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  // Packet to decode
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [4:0]        opcode,
  output logic              i_bit,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [31:0]       immx,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
`endif
  output logic [ADDR_W-1:0] branch_target
);

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic [31:0]       inst_q;
  logic              req_q;
  logic              valid_q;
  logic              drop_q;

  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_off;
  logic              xfer;

  // Redirect targets are word aligned; the low two bits are cleared.
  assign redir_pc = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign pc_inc   = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
  assign xfer     = valid_q && inst_ready;

  // Fetch FSM with registered handshake outputs; redirect takes priority everywhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      inst_pc_q <= RESET_PC;
      inst_q    <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (redirect) begin
            pc_q <= redir_pc;
          end else begin
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          // The outstanding request completes at its original address even after a
          // redirect; its data is then dropped.
          if (redirect) begin
            pc_q <= redir_pc;
          end
          if (imem_ack) begin
            req_q <= 1'b0;
            if (redirect || drop_q) begin
              drop_q  <= 1'b0;
              state_q <= StFetch;
            end else begin
              inst_q    <= imem_data;
              inst_pc_q <= addr_q;
              valid_q   <= 1'b1;
              state_q   <= StHold;
            end
          end else if (redirect) begin
            drop_q <= 1'b1;
          end
        end
        StHold: begin
          if (redirect) begin
            pc_q    <= redir_pc;
            valid_q <= 1'b0;
            state_q <= StFetch;
          end else if (xfer) begin
            pc_q    <= pc_inc;
            valid_q <= 1'b0;
            state_q <= StFetch;
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state_q <= StFetch;
        end
      endcase
    end
  end

  // Field split and immediate extension straight from the instruction register.
  always_comb begin
    opcode = inst_q[31:27];
    i_bit  = inst_q[26];
    rd     = inst_q[25:22];
    rs1    = inst_q[21:18];
    rs2    = inst_q[17:14];
    unique case (inst_q[17:16])
      2'b01:   immx = {16'h0000, inst_q[15:0]};
      2'b10:   immx = {inst_q[15:0], 16'h0000};
      default: immx = {{16{inst_q[15]}}, inst_q[15:0]};
    endcase
  end

  // Branch offset is a signed word count; the sum wraps at ADDR_W bits.
  assign br_off        = {{(ADDR_W-27){inst_q[26]}}, inst_q[26:0]} << 2;
  assign branch_target = inst_pc_q + br_off;

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] stall_q;
  logic        stall;

  assign stall = (state_q == StWait) || ((state_q == StHold) && !inst_ready);

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (xfer && (fetched_q != 32'hFFFF_FFFF)) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (stall && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule
